// File: rtl/free_list_manager.sv
// Rename free list: a circular queue of free physical registers plus branch
// checkpoints that snapshot the head so a mispredict can hand registers back.
module free_list_manager #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int CKPTS     = 4,
  localparam int CAP = PHYS_REGS - ARCH_REGS,
  localparam int PW  = $clog2(PHYS_REGS),
  localparam int AW  = $clog2(CAP),
  localparam int CW  = (CKPTS > 1) ? $clog2(CKPTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_valid,
  output logic [PW-1:0] alloc_preg,
  input  logic          reclaim_valid,
  input  logic [PW-1:0] reclaim_preg,
  input  logic          ckpt_req,
  output logic          ckpt_ready,
  output logic [CW-1:0] ckpt_id,
  input  logic          ckpt_release,
  input  logic [CW-1:0] ckpt_release_id,
  input  logic          recover,
  input  logic [CW-1:0] recover_id,
  output logic [AW:0]   free_count,
  output logic          overflow_err
);

  logic [PW-1:0]    r_entry   [CAP];
  logic [AW:0]      r_head;
  logic [AW:0]      r_tail;
  logic [CKPTS-1:0] r_valid;
  logic [CKPTS-1:0] r_younger [CKPTS];
  logic [AW:0]      r_saved   [CKPTS];
  logic             r_err;

  logic [AW:0]      w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_do_alloc;
  logic             w_reclaim_ovf;
  logic             w_do_reclaim;
  logic             w_rec_hit;
  logic             w_rec_ok;
  logic             w_rel_ok;
  logic             w_proto_err;
  logic             w_do_ckpt;
  logic [AW:0]      w_head_post;
  logic [CW-1:0]    w_free_id;
  logic             w_any_free;
  logic [CKPTS-1:0] w_rec_onehot;
  logic [CKPTS-1:0] w_valid_nxt;

  // Wrap-bit pointers make full (count == CAP) and empty (count == 0) distinct.
  assign w_count     = r_tail - r_head;
  assign w_empty     = (w_count == {(AW+1){1'b0}});
  assign w_full      = (w_count == (AW+1)'(CAP));

  assign alloc_valid = ~w_empty;
  assign alloc_preg  = r_entry[r_head[AW-1:0]];
  assign free_count  = w_count;
  assign overflow_err = r_err;
  assign ckpt_ready  = w_any_free;
  assign ckpt_id     = w_free_id;

  // A recover squashes this cycle's rename-side requests but not commit's reclaim.
  assign w_do_alloc    = alloc_req & ~w_empty & ~recover;
  assign w_reclaim_ovf = reclaim_valid & w_full & ~w_do_alloc;
  assign w_do_reclaim  = reclaim_valid & ~w_reclaim_ovf;
  assign w_rec_hit     = r_valid[recover_id];
  assign w_rec_ok      = recover & w_rec_hit;
  assign w_rel_ok      = ckpt_release & r_valid[ckpt_release_id];
  assign w_proto_err   = w_reclaim_ovf
                       | (recover & ~w_rec_hit)
                       | (ckpt_release & ~r_valid[ckpt_release_id]);
  assign w_do_ckpt     = ckpt_req & w_any_free & ~recover;
  assign w_head_post   = r_head + {{AW{1'b0}}, w_do_alloc};
  assign w_rec_onehot  = {{(CKPTS-1){1'b0}}, 1'b1} << recover_id;

  // Lowest-index free checkpoint slot.
  always_comb begin
    w_free_id  = {CW{1'b0}};
    w_any_free = 1'b0;
    for (int i = CKPTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_id  = CW'(i);
        w_any_free = 1'b1;
      end else begin
        w_free_id  = w_free_id;
      end
    end
  end

  // Next checkpoint valid bits; recover and release on the same slot both clear it.
  always_comb begin
    w_valid_nxt = r_valid;
    if (w_rec_ok) begin
      w_valid_nxt = w_valid_nxt & ~r_younger[recover_id] & ~w_rec_onehot;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
    if (w_rel_ok) begin
      w_valid_nxt[ckpt_release_id] = 1'b0;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
    if (w_do_ckpt) begin
      w_valid_nxt[w_free_id] = 1'b1;
    end else begin
      w_valid_nxt = w_valid_nxt;
    end
  end

  // Pointer, storage, checkpoint and error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= {(AW+1){1'b0}};
      r_tail  <= (AW+1)'(CAP);
      r_valid <= {CKPTS{1'b0}};
      r_err   <= 1'b0;
      for (int i = 0; i < CAP; i++) begin
        r_entry[i] <= PW'(ARCH_REGS + i);
      end
      for (int k = 0; k < CKPTS; k++) begin
        r_younger[k] <= {CKPTS{1'b0}};
        r_saved[k]   <= {(AW+1){1'b0}};
      end
    end else begin
      if (w_do_reclaim) begin
        r_entry[r_tail[AW-1:0]] <= reclaim_preg;
        r_tail                  <= r_tail + {{AW{1'b0}}, 1'b1};
      end
      if (w_rec_ok) begin
        r_head <= r_saved[recover_id];
      end else begin
        r_head <= w_head_post;
      end
      r_valid <= w_valid_nxt;
      r_err   <= r_err | w_proto_err;
      // The new slot is younger than every live slot; its own row starts empty.
      if (w_do_ckpt) begin
        r_saved[w_free_id] <= w_head_post;
        for (int k = 0; k < CKPTS; k++) begin
          if (CW'(k) == w_free_id) begin
            r_younger[k] <= {CKPTS{1'b0}};
          end else if (r_valid[k]) begin
            r_younger[k][w_free_id] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
